tick_chain_counter: RTL

//   Parametrised, synthesizable chained-register sequencer. On start, loads STAGES registers at fixed

---
 rtl/tcc_pkg.sv | 17 +
 rtl/tick_chain_counter_tick_gen.sv | 26 ++
 rtl/tick_chain_counter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tcc_pkg.sv
// Shared types and width helpers for the tick chain counter.
package tcc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned CNT_W(int unsigned spacing);
    return $clog2(spacing + 1);
  endfunction

  function automatic int unsigned IDX_W(int unsigned stages);
    return $clog2(stages);
  endfunction

endpackage

// File: rtl/tick_chain_counter_tick_gen.sv
// Free-running period counter; tick is asserted combinationally on the enabled wrap cycle.
module tick_gen #(
  parameter int unsigned PERIOD = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] r_cnt;

  assign tick = en && (r_cnt == PW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      if (tick) r_cnt <= '0;
      else      r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/tick_chain_counter.sv
// Chained-register sequencer: loads stages at fixed spacing, then stage0 advances on period ticks.
module tick_chain_counter
  import tcc_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned SPACING = 10,
  parameter int unsigned PERIOD  = 7,
  parameter int unsigned STEP    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          seed,
  input  logic                      en,
  output logic [STAGES*WIDTH-1:0]   val,
  output logic [STAGES-1:0]         valid,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CW = CNT_W(SPACING);
  localparam int unsigned IW = IDX_W(STAGES);

  state_t            r_state;
  logic [CW-1:0]     r_spc;
  logic [IW-1:0]     r_idx;
  logic [WIDTH-1:0]  r_seed;
  logic [STAGES-1:0] r_valid;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_stage [STAGES];

  logic              w_tick;
  logic              w_load;
  logic [WIDTH-1:0]  w_step;

  assign w_load = (r_state == RUN) && (r_spc == CW'(SPACING - 1));
  assign w_step = WIDTH'(STEP);

  tick_gen #(.PERIOD(PERIOD)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (w_tick)
  );

  // Sequencing FSM with spacing and stage-index counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_spc   <= '0;
      r_idx   <= '0;
      r_seed  <= '0;
      r_valid <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state                <= RUN;
            r_seed                 <= seed;
            r_spc                  <= '0;
            r_idx                  <= '0;
            r_busy                 <= 1'b1;
            r_valid[STAGES-1:1]    <= '0;
          end
        end
        RUN: begin
          if (w_load) begin
            r_spc          <= '0;
            r_valid[r_idx] <= 1'b1;
            if (r_idx == IW'(STAGES - 1)) begin
              r_state <= IDLE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_spc <= r_spc + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage registers; a load always takes precedence over a same-edge increment.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset) begin
          r_stage[0] <= '0;
        end else if (w_load && (r_idx == IW'(0))) begin
          r_stage[0] <= r_seed;
        end else if (w_tick && r_valid[0]) begin
          r_stage[0] <= r_stage[0] + w_step;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (reset) begin
          r_stage[k] <= '0;
        end else if (w_load && (r_idx == IW'(k))) begin
          r_stage[k] <= r_stage[k-1] + w_step;
        end
      end
    end
    assign val[k*WIDTH +: WIDTH] = r_stage[k];
  end

  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
